// File: rtl/udlx_ctrl_pkg.sv
// Shared control definitions for the uDLX pipeline sequencers.
package udlx_ctrl_pkg;
  localparam int REG_ADDR_WIDTH_DEF = 5;
  localparam int REG_ZERO           = 0;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_IMEM_WAIT = 2'd1,
    ST_DMEM_WAIT = 2'd2
  } hz_state_e;
endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: the load in EX writes a register the ID instruction reads.
module hazard_detect
  import udlx_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
  input  logic [REG_ADDR_WIDTH-1:0] id_rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt_addr,
  input  logic                      id_uses_rt,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  output logic                      lu
);
  logic rd_live;

  assign rd_live = ex_rd_addr != REG_ADDR_WIDTH'(REG_ZERO);
  assign lu = ex_mem_read && rd_live &&
              ((ex_rd_addr == id_rs_addr) || (id_uses_rt && (ex_rd_addr == id_rt_addr)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// uDLX stall/flush sequencer: dmem wait > branch > load-use > imem wait.
// HAZARD_PERF_CNT_EN adds saturating stall/flush counters; otherwise they read 0.
module pipeline_hazard_ctrl
  import udlx_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int IMEM_LATENCY   = 1,
  parameter int PERF_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt_addr,
  input  logic                      id_uses_rt,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  input  logic                      branch_taken,
  input  logic                      dmem_req,
  input  logic                      dmem_ready,
  output logic                      pc_write_en,
  output logic                      if_id_stall,
  output logic                      if_id_flush,
  output logic                      id_ex_flush,
  output logic                      pipe_freeze,
  output logic [PERF_CNT_WIDTH-1:0] stall_cycles,
  output logic [PERF_CNT_WIDTH-1:0] flush_events
);
  localparam int CW = (IMEM_LATENCY > 0) ? $clog2(IMEM_LATENCY + 1) : 1;
  localparam logic [CW-1:0] LAT = CW'(IMEM_LATENCY);
  localparam hz_state_e FETCH_ST = (IMEM_LATENCY > 0) ? ST_IMEM_WAIT : ST_RUN;

  hz_state_e     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          lu, dmem_wait;
  logic          pc_c, stall_c, ifl_c, ifx_c, frz_c;

  hazard_detect #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_hd (
    .id_rs_addr  (id_rs_addr),
    .id_rt_addr  (id_rt_addr),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rd_addr  (ex_rd_addr),
    .lu          (lu)
  );

  assign dmem_wait = dmem_req && !dmem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pc_c    = 1'b0;
    stall_c = 1'b0;
    ifl_c   = 1'b0;
    ifx_c   = 1'b0;
    frz_c   = 1'b0;
    if (dmem_wait) begin
      // EX is frozen too, so a pending branch is simply re-presented later.
      frz_c   = 1'b1;
      stall_c = 1'b1;
      state_n = ST_DMEM_WAIT;
    end else if (branch_taken) begin
      pc_c    = 1'b1;
      ifl_c   = 1'b1;
      ifx_c   = 1'b1;
      cnt_n   = LAT;
      state_n = FETCH_ST;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (lu) begin
            stall_c = 1'b1;
            ifx_c   = 1'b1;
          end else begin
            pc_c    = 1'b1;
            cnt_n   = LAT;
            state_n = FETCH_ST;
          end
        end
        ST_IMEM_WAIT: begin
          stall_c = 1'b1;
          ifx_c   = 1'b1;
          cnt_n   = (cnt != '0) ? cnt - 1'b1 : '0;
          state_n = (cnt_n == '0) ? ST_RUN : ST_IMEM_WAIT;
        end
        default: begin
          // Release cycle: back end drains while ID holds with a bubble behind it.
          stall_c = 1'b1;
          ifx_c   = 1'b1;
          state_n = (cnt != '0) ? ST_IMEM_WAIT : ST_RUN;
        end
      endcase
    end
  end

  assign pc_write_en = rst_n & pc_c;
  assign if_id_stall = rst_n & stall_c;
  assign if_id_flush = rst_n & ifl_c;
  assign id_ex_flush = rst_n & ifx_c;
  assign pipe_freeze = rst_n & frz_c;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_write_en && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
      if (if_id_flush && !(&flush_events))  flush_events <= flush_events + 1'b1;
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the uDLX 5-stage pipeline. Drives the PC write enable plus the stall/flush controls of IF/ID, ID/EX and the back-end freeze. Decisions are based on load-use hazards, taken branches resolved in EX, fixed-latency instruction SRAM wait cycles and handshaked data-memory wait states. Sits beside the datapath in the core top level; purely control, carries no data.

Parameters:
REG_ADDR_WIDTH, 5, register-file address width
IMEM_LATENCY, 1, extra wait cycles per instruction fetch after any PC update (0 = single-cycle SRAM)
PERF_CNT_WIDTH, 16, width of optional performance counters

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active low
id_rs_addr  input  REG_ADDR_WIDTH  source register A of instruction in ID
id_rt_addr  input  REG_ADDR_WIDTH  source register B of instruction in ID
id_uses_rt  input  1  instruction in ID reads rt
ex_mem_read  input  1  instruction in EX is a load
ex_rd_addr  input  REG_ADDR_WIDTH  destination register of instruction in EX
branch_taken  input  1  taken branch/jump resolved in EX this cycle
dmem_req  input  1  MEM stage is accessing data memory
dmem_ready  input  1  data memory completes the access this cycle
pc_write_en  output  1  PC may update
if_id_stall  output  1  hold IF/ID contents
if_id_flush  output  1  clear IF/ID to NOP
id_ex_flush  output  1  insert bubble into ID/EX
pipe_freeze  output  1  hold ID/EX, EX/MEM and MEM/WB
stall_cycles  output  PERF_CNT_WIDTH  optional counter (see Optional Feature)
flush_events  output  PERF_CNT_WIDTH  optional counter

Behaviour:
- Reset: rst_n low gives state RUN and wait counter 0. All outputs are forced 0 while rst_n is low, including pc_write_en.
- FSM states: RUN, IMEM_WAIT, DMEM_WAIT. Outputs are combinational from state and inputs.
- Load-use hazard (lu): ex_mem_read && ex_rd_addr!=0 && (ex_rd_addr==id_rs_addr || (id_uses_rt && ex_rd_addr==id_rt_addr)).
- Priority each cycle, highest first: dmem wait, branch, lu, imem wait.
- DMEM wait (dmem_req && !dmem_ready, any state):
  - Outputs: pipe_freeze=1, if_id_stall=1, pc_write_en=0, no flushes.
  - Next state is DMEM_WAIT; the imem counter is frozen.
  - branch_taken is ignored here, because EX is frozen and the branch is re-presented after release.
  - Leaving DMEM_WAIT: on dmem_ready, go to IMEM_WAIT if the counter is nonzero, else RUN.
- Branch (branch_taken, no dmem wait):
  - Outputs: if_id_flush=1, id_ex_flush=1, pc_write_en=1.
  - Counter loads IMEM_LATENCY; go to IMEM_WAIT if IMEM_LATENCY>0, else RUN.
  - Overrides lu and any in-progress imem wait.
- lu (RUN only): pc_write_en=0, if_id_stall=1, id_ex_flush=1 for exactly one cycle. The load then leaves EX and the condition clears without an extra state.
- Normal advance (RUN, no event): pc_write_en=1, and the counter loads IMEM_LATENCY. If IMEM_LATENCY>0, next state is IMEM_WAIT.
- IMEM_WAIT:
  - Outputs: pc_write_en=0, if_id_stall=1, id_ex_flush=1.
  - Counter decrements each cycle; go to RUN when it reaches 0.
  - lu arising in this state is absorbed, since ID is already held.
- Counter width is $clog2(IMEM_LATENCY+1), minimum 1. It never wraps; decrement saturates at 0.
- if_id_flush and if_id_stall are never both 1.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined: stall_cycles increments on every cycle with pc_write_en=0 outside reset. flush_events increments on every cycle with if_id_flush=1. Both saturate at all-ones and are cleared by rst_n.
- Undefined: both ports remain and are tied to 0; no counter flops exist.

Decomposition:
- Shared package udlx_ctrl_pkg holds:
  - FSM state encoding (ST_RUN, ST_IMEM_WAIT, ST_DMEM_WAIT)
  - REG_ZERO constant
  - default REG_ADDR_WIDTH
- One natural sub-module: hazard_detect, the combinational lu comparator. Everything else is inline.

Test Plan:
- Load r3 in EX, ID reads rs=3 (IMEM_LATENCY=0) -> one cycle with pc_write_en=0, if_id_stall=1, id_ex_flush=1; next cycle pc_write_en=1.
- Load writing r0, ID reads r0 -> no stall.
- branch_taken while lu is also true -> if_id_flush=1, id_ex_flush=1, pc_write_en=1, no if_id_stall.
- IMEM_LATENCY=2, free run -> pc_write_en pattern 1,0,0,1,0,0.
- dmem_req=1 with dmem_ready low for 3 cycles, branch_taken held high -> pipe_freeze=1 for 3 cycles with no flush; the flush fires on the release cycle.
- rst_n asserted during IMEM_WAIT -> all outputs 0 immediately. After release, state is RUN and pc_write_en=1 on the first cycle (IMEM_LATENCY=0 build); with HAZARD_PERF_CNT_EN both counters read 0.
